// File: rtl/param_array_checker.sv
// Streaming lane checker: captures a LANES x WIDTH vector, compares one lane per
// cycle against EXPECT, keeps saturating stats. Define PARAM_ARRAY_CHECKER_ASSERT_EN for assertions.
module param_array_checker #(
  parameter int LANES = 4,
  parameter int WIDTH = 4,
  parameter logic [LANES-1:0][WIDTH-1:0] EXPECT = '0,
  parameter int CNT_W = 8,
  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1,
  localparam int PC_W  = $clog2(LANES + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic                   clr_stats,
  output logic                   done,
  output logic                   pass,
  output logic                   err_sticky,
  output logic [CNT_W-1:0]       mismatch_cnt,
  output logic [CNT_W-1:0]       vec_cnt,
  output logic [IDX_W-1:0]       first_bad_lane
);

  // Handshake: a vector transfers on a rising edge where in_valid && in_ready.
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [1:0]             state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [PC_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]       cand_q, cand_d;
  logic [LANES*WIDTH-1:0] hold_q, hold_d;
  logic                   in_ready_q, in_ready_d;
  logic                   done_q, done_d;
  logic                   pass_q, pass_d;
  logic                   err_q, err_d;
  logic [CNT_W-1:0]       mis_q, mis_d;
  logic [CNT_W-1:0]       vec_q, vec_d;
  logic [IDX_W-1:0]       fbl_q, fbl_d;

  logic [WIDTH-1:0] lane_sel;
  logic             lane_mismatch;
  logic [CNT_W:0]   mis_sum;
  logic [CNT_W:0]   vec_sum;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    cand_d     = cand_q;
    hold_d     = hold_q;
    err_d      = err_q;
    mis_d      = mis_q;
    vec_d      = vec_q;
    fbl_d      = fbl_q;

    lane_sel      = hold_q[idx_q*WIDTH +: WIDTH];
    lane_mismatch = (lane_sel != EXPECT[idx_q]);
    // One bit wider than the counters so overflow is visible before clamping.
    mis_sum       = {1'b0, mis_q} + (CNT_W+1)'(cnt_q);
    vec_sum       = {1'b0, vec_q} + (CNT_W+1)'(1);

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          hold_d  = in_data;
          idx_d   = '0;
          cnt_d   = '0;
          cand_d  = '0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (lane_mismatch) begin
          cnt_d = cnt_q + PC_W'(1);
          if (cnt_q == '0) cand_d = idx_q;
        end
        if (idx_q == LAST_IDX) state_d = S_DONE;
        else                   idx_d   = idx_q + IDX_W'(1);
      end
      S_DONE: begin
        state_d = S_IDLE;
        vec_d   = vec_sum[CNT_W] ? CNT_MAX : vec_sum[CNT_W-1:0];
        mis_d   = mis_sum[CNT_W] ? CNT_MAX : mis_sum[CNT_W-1:0];
        if ((cnt_q != '0) && !err_q) begin
          err_d = 1'b1;
          fbl_d = cand_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Clearing only touches statistics; it overrides a same-cycle DONE update.
    if (clr_stats) begin
      err_d = 1'b0;
      mis_d = '0;
      vec_d = '0;
      fbl_d = '0;
    end

    in_ready_d = (state_d == S_IDLE);
    done_d     = (state_d == S_DONE);
    pass_d     = (state_d == S_DONE) && (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      cand_q     <= '0;
      hold_q     <= '0;
      in_ready_q <= 1'b1;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= 1'b0;
      mis_q      <= '0;
      vec_q      <= '0;
      fbl_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      cand_q     <= cand_d;
      hold_q     <= hold_d;
      in_ready_q <= in_ready_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_q      <= err_d;
      mis_q      <= mis_d;
      vec_q      <= vec_d;
      fbl_q      <= fbl_d;
    end
  end

  assign in_ready       = in_ready_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_sticky     = err_q;
  assign mismatch_cnt   = mis_q;
  assign vec_cnt        = vec_q;
  assign first_bad_lane = fbl_q;

`ifdef PARAM_ARRAY_CHECKER_ASSERT_EN
  always @(posedge clk) begin
    if (done_q) assert (pass_q);
  end

  // A producer that has raised valid must hold it until the transfer happens.
  valid_held_until_ready: assert property (@(posedge clk) disable iff (rst)
    (in_valid && !in_ready_q) |=> in_valid);
`else
  // Assertions not compiled in this build.
`endif

endmodule

// File: tb/tb_param_array_checker.sv
// Directed bench for param_array_checker: default-EXPECT instance plus an EXPECT=16'h4321
// instance for saturation; scoreboard queue of expected pass bits.
module tb_param_array_checker;

  localparam logic [15:0] EXP1 = 16'h4321;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  vld, clr, rdy, done_v, pass_v, err_v;
  logic [15:0] din [2];
  logic [7:0]  mc  [2];
  logic [7:0]  vc  [2];
  logic [1:0]  fbl [2];

  int checks = 0;
  int errors = 0;
  logic [0:0] exp_q[$];

  int   m_vec [2];
  int   m_mis [2];
  logic m_err [2];
  int   m_fbl [2];

  always #5 clk = ~clk;

  param_array_checker u_dut0 (
    .clk(clk), .rst(rst), .in_valid(vld[0]), .in_ready(rdy[0]), .in_data(din[0]),
    .clr_stats(clr[0]), .done(done_v[0]), .pass(pass_v[0]), .err_sticky(err_v[0]),
    .mismatch_cnt(mc[0]), .vec_cnt(vc[0]), .first_bad_lane(fbl[0])
  );

  param_array_checker #(.EXPECT(EXP1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(vld[1]), .in_ready(rdy[1]), .in_data(din[1]),
    .clr_stats(clr[1]), .done(done_v[1]), .pass(pass_v[1]), .err_sticky(err_v[1]),
    .mismatch_cnt(mc[1]), .vec_cnt(vc[1]), .first_bad_lane(fbl[1])
  );

  // ---------------- clock/reset helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_of(input int u);
    return (u == 1) ? EXP1 : 16'h0000;
  endfunction

  function automatic int lane_mism(input logic [15:0] d, input logic [15:0] e);
    int m = 0;
    for (int i = 0; i < 4; i++) if (d[i*4 +: 4] !== e[i*4 +: 4]) m++;
    return m;
  endfunction

  function automatic int first_bad(input logic [15:0] d, input logic [15:0] e);
    int b = 0;
    for (int i = 3; i >= 0; i--) if (d[i*4 +: 4] !== e[i*4 +: 4]) b = i;
    return b;
  endfunction

  // ---------------- statistics model ----------------
  task automatic model_add(input int u, input logic [15:0] d);
    int m;
    m = lane_mism(d, exp_of(u));
    m_vec[u] = (m_vec[u] + 1 > 255) ? 255 : m_vec[u] + 1;
    m_mis[u] = (m_mis[u] + m > 255) ? 255 : m_mis[u] + m;
    if (m != 0 && !m_err[u]) begin
      m_err[u] = 1'b1;
      m_fbl[u] = first_bad(d, exp_of(u));
    end
  endtask

  task automatic model_clear(input int u);
    m_vec[u] = 0;
    m_mis[u] = 0;
    m_err[u] = 1'b0;
    m_fbl[u] = 0;
  endtask

  task automatic check_stats(input int u, input string tag);
    chk({tag, "_err_sticky"}, err_v[u], m_err[u]);
    chk({tag, "_mismatch_cnt"}, mc[u], m_mis[u]);
    chk({tag, "_vec_cnt"}, vc[u], m_vec[u]);
    chk({tag, "_first_bad_lane"}, fbl[u], m_fbl[u]);
    chk({tag, "_done_idle"}, done_v[u], 1'b0);
    chk({tag, "_pass_idle"}, pass_v[u], 1'b0);
  endtask

  // ---------------- driver ----------------
  // Sends one vector, scrambles in_data during CHECK, returns in the DONE cycle.
  task automatic run_vec(input int u, input logic [15:0] d, input string tag);
    int n;
    n = 0;
    while (!rdy[u] && n < 20) begin step(); n++; end
    chk({tag, "_ready"}, rdy[u], 1'b1);
    vld[u] = 1'b1;
    din[u] = d;
    exp_q.push_back(lane_mism(d, exp_of(u)) == 0);
    step();
    vld[u] = 1'b0;
    din[u] = 16'($urandom);
    n = 1;
    while (!done_v[u] && n < 20) begin step(); n++; end
    chk({tag, "_latency"}, n, 5);
    chk({tag, "_pass"}, pass_v[u], exp_q.pop_front());
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [6:0] pat;
    int dones, n;
    rst = 1'b1;
    vld = '0;
    clr = '0;
    din[0] = '0;
    din[1] = '0;
    model_clear(0);
    model_clear(1);
    repeat (3) step();
    rst = 1'b0;

    // reset values
    chk("rst_in_ready", rdy[0], 1'b1);
    check_stats(0, "rst");
    check_stats(1, "rst_u1");

    // all-zero vector against default EXPECT
    run_vec(0, 16'h0000, "zero");
    model_add(0, 16'h0000);
    step();
    check_stats(0, "zero");

    // lane 2 mismatch
    run_vec(0, 16'h0F00, "lane2");
    model_add(0, 16'h0F00);
    step();
    check_stats(0, "lane2");
    chk("lane2_fbl_const", fbl[0], 2);

    // passing vector after failure keeps sticky state
    run_vec(0, 16'h0000, "after_fail");
    model_add(0, 16'h0000);
    step();
    check_stats(0, "after_fail");

    // in_valid held high: ready pattern and one capture per 6 cycles
    pat = '0;
    dones = 0;
    vld[0] = 1'b1;
    for (int i = 0; i < 7; i++) begin
      pat[6-i] = rdy[0];
      if (rdy[0]) begin
        din[0] = 16'h0000;
        exp_q.push_back(1'b1);
      end else begin
        din[0] = 16'($urandom);
      end
      if (done_v[0]) begin
        dones++;
        chk("cont_pass1", pass_v[0], exp_q.pop_front());
      end
      step();
    end
    vld[0] = 1'b0;
    din[0] = 16'hFFFF;
    chk("cont_ready_pattern", pat, 7'b1000001);
    chk("cont_done_count", dones, 1);
    n = 0;
    while (!done_v[0] && n < 10) begin step(); n++; end
    chk("cont_done2", done_v[0], 1'b1);
    chk("cont_pass2", pass_v[0], exp_q.pop_front());
    model_add(0, 16'h0000);
    model_add(0, 16'h0000);
    step();
    check_stats(0, "cont");

    // clr_stats in the DONE cycle of a failing vector
    run_vec(0, 16'h000F, "clr");
    chk("clr_done", done_v[0], 1'b1);
    clr[0] = 1'b1;
    step();
    clr[0] = 1'b0;
    model_clear(0);
    check_stats(0, "clr");

    // rst during the 2nd CHECK cycle aborts the vector
    vld[0] = 1'b1;
    din[0] = 16'h0F0F;
    step();
    vld[0] = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_clear(0);
    model_clear(1);
    chk("abort_in_ready", rdy[0], 1'b1);
    check_stats(0, "abort");
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      if (done_v[0]) dones++;
      step();
    end
    chk("abort_no_done", dones, 0);
    run_vec(0, 16'h1000, "post_abort");
    model_add(0, 16'h1000);
    step();
    check_stats(0, "post_abort");

    // saturation with EXPECT=16'h4321
    for (int i = 0; i < 300; i++) begin
      run_vec(1, 16'hFFFF, "sat");
      model_add(1, 16'hFFFF);
      step();
      check_stats(1, "sat");
    end
    chk("sat_mismatch_final", mc[1], 8'd255);
    chk("sat_vec_final", vc[1], 8'd255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
